// File: rtl/genius_round_ctrl.sv
// Round sequencer for the Genius (Simon) game: setup window, colour replay, key checking, WIN/LOSE.
// Optional build macro GENIUS_TIMEOUT_EN adds a per-key player timeout of WAIT_TICKS cycles.
module genius_round_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int SHOW_TICKS = 50000000,
    parameter int WAIT_TICKS = 250000000
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              enter,
    input  logic [7:0]        setup,
    input  logic              key_valid,
    input  logic [1:0]        key_code,
    input  logic [1:0]        seq_data,
    output logic              E_setup,
    output logic [ADDR_W-1:0] seq_addr,
    output logic              led_on,
    output logic [1:0]        led_code,
    output logic [ADDR_W:0]   round,
    output logic              win,
    output logic              lose,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHOW  = 3'd2,
        ST_USER  = 3'd3,
        ST_CHECK = 3'd4,
        ST_WIN   = 3'd5,
        ST_LOSE  = 3'd6
    } state_t;

    localparam int TICK_W  = ($clog2(2 * SHOW_TICKS) < 1) ? 1 : $clog2(2 * SHOW_TICKS);
    localparam int TIMER_W = ($clog2(WAIT_TICKS) < 1) ? 1 : $clog2(WAIT_TICKS);
    localparam int MAX_SYM = 1 << ADDR_W;

    // One symbol slot is SHOW_TICKS lit followed by SHOW_TICKS dark.
    localparam logic [TICK_W-1:0] TICK_LED_END = TICK_W'(SHOW_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_SYM_END = TICK_W'(2 * SHOW_TICKS - 1);

    function automatic logic [ADDR_W:0] target_for(input logic [1:0] sel);
        int t;
        t = 4 * (int'(sel) + 1);
        if (t > MAX_SYM) t = MAX_SYM;
        return (ADDR_W+1)'(t);
    endfunction

    state_t              r_state;
    logic [ADDR_W-1:0]   r_seq_addr;
    logic [ADDR_W:0]     r_round;
    logic [ADDR_W:0]     r_target;
    logic [TICK_W-1:0]   r_tick;
    logic                r_led_on;
    logic                r_e_setup;
    logic                r_win;
    logic                r_lose;

    logic [ADDR_W:0]     w_last_idx;
    logic                w_at_last;
    logic                w_key_match;
    logic                w_unused_setup;

    assign w_last_idx     = r_round - 1'b1;
    assign w_at_last      = ({1'b0, r_seq_addr} == w_last_idx);
    assign w_key_match    = (key_code == seq_data);
    assign w_unused_setup = ^setup[7:2];

`ifdef GENIUS_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(WAIT_TICKS - 1);
    logic [TIMER_W-1:0]  r_timer;
`else
    logic [TIMER_W-1:0]  w_unused_timer;
    assign w_unused_timer = TIMER_W'(WAIT_TICKS - 1);
`endif

    always_ff @(posedge CLK) begin
        if (!R) begin
            r_state    <= ST_INIT;
            r_seq_addr <= '0;
            r_round    <= '0;
            r_target   <= '0;
            r_tick     <= '0;
            r_led_on   <= 1'b0;
            r_e_setup  <= 1'b0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
            r_timer    <= '0;
`endif
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (enter) begin
                        r_state   <= ST_SETUP;
                        r_e_setup <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (enter) begin
                        r_state    <= ST_SHOW;
                        r_e_setup  <= 1'b0;
                        r_target   <= target_for(setup[1:0]);
                        r_round    <= (ADDR_W+1)'(1);
                        r_seq_addr <= '0;
                        r_tick     <= '0;
                        r_led_on   <= 1'b1;
                    end
                end

                ST_SHOW: begin
                    if (r_tick == TICK_SYM_END) begin
                        r_tick <= '0;
                        if (w_at_last) begin
                            r_state    <= ST_USER;
                            r_seq_addr <= '0;
`ifdef GENIUS_TIMEOUT_EN
                            r_timer    <= '0;
`endif
                        end else begin
                            r_seq_addr <= r_seq_addr + 1'b1;
                            r_led_on   <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                        if (r_tick == TICK_LED_END) r_led_on <= 1'b0;
                    end
                end

                ST_USER: begin
`ifdef GENIUS_TIMEOUT_EN
                    r_timer <= r_timer + 1'b1;
`endif
                    if (key_valid) begin
                        if (w_key_match) begin
                            if (w_at_last) r_state <= ST_CHECK;
                            else           r_seq_addr <= r_seq_addr + 1'b1;
`ifdef GENIUS_TIMEOUT_EN
                            r_timer <= '0;
`endif
                        end else begin
                            r_state <= ST_LOSE;
                            r_lose  <= 1'b1;
                        end
                    end
`ifdef GENIUS_TIMEOUT_EN
                    // A matching key in the expiry cycle wins over the timeout.
                    else if (r_timer == TIMER_END) begin
                        r_state <= ST_LOSE;
                        r_lose  <= 1'b1;
                    end
`endif
                end

                ST_CHECK: begin
                    if (r_round == r_target) begin
                        r_state <= ST_WIN;
                        r_win   <= 1'b1;
                    end else begin
                        r_state    <= ST_SHOW;
                        r_round    <= r_round + 1'b1;
                        r_seq_addr <= '0;
                        r_tick     <= '0;
                        r_led_on   <= 1'b1;
                    end
                end

                ST_WIN, ST_LOSE: begin
                    if (enter) begin
                        r_state    <= ST_INIT;
                        r_win      <= 1'b0;
                        r_lose     <= 1'b0;
                        r_round    <= '0;
                        r_target   <= '0;
                        r_seq_addr <= '0;
                    end
                end

                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign E_setup  = r_e_setup;
    assign seq_addr = r_seq_addr;
    assign led_on   = r_led_on;
    assign led_code = r_led_on ? seq_data : 2'b00;
    assign round    = r_round;
    assign win      = r_win;
    assign lose     = r_lose;
    assign state_o  = r_state;

endmodule
